multi_cycle_ctrl: RTL
=====================

MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000; PC value loaded at reset.
REQ-003 SHALL have these ports, clock and reset first:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  32  fetch address; equals pc.
- imem_ack  in  1  fetch complete; imem_rdata valid this cycle.
- imem_rdata  in  32  fetched instruction.
- inst  out  32  latched instruction, drives instruction decoder data_in_inst.
- operation  in  32  one-hot decoder output. Bit map: 31 ADDI, 30 SLTI, 29 ANDI, 28 ORI, 27 XORI, 26 LUI, 25 AUIPC, 24 SLLI, 23 SRLI, 22 SRAI, 21 ADD, 20 SUB, 19 XOR, 18 OR, 17 AND, 16 SLL, 15 SRL, 14 SLT, 13 LB, 12 LH, 11 LW, 10 SB, 9 SH, 8 SW, 7 JAL, 6 JALR, 5 BEQ, 4 BNE, 3 BLT, 2 BGE, 1 BLTU, 0 BGEU.
- branch_cond  in  1  ALU compare result; valid in EXECUTE.
- target_addr  in  32  datapath branch/jump target; valid in EXECUTE.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  1 = store, 0 = load; valid while dmem_req=1.
- dmem_ack  in  1  data access complete.
- rf_we  out  1  register-file write strobe.
- pc  out  32  current program counter.
- halted  out  1  controller stopped.
- instret  out  32  retired-instruction count.

Function
REQ-004 SHALL implement the states FETCH, DECODE, EXECUTE, MEM, WB, HALT, with one-cycle minimum residency in each state.
REQ-005 FETCH: imem_req=1 until imem_ack is sampled high; on ack, latch inst<=imem_rdata and go to DECODE. The controller SHALL NOT deassert imem_req before ack.
REQ-006 DECODE: operation not exactly one-hot (zero or more than one bit set) -> HALT; otherwise -> EXECUTE.
REQ-007 EXECUTE: from the operation class, go to:
- loads/stores (bits 13..8) -> MEM.
- ALU ops, LUI, AUIPC, JAL, JALR (bits 31..14, 7, 6) -> WB.
- branches (bits 5..0) -> FETCH.
REQ-008 MEM: dmem_req=1 and dmem_we=store-class until dmem_ack; on ack, load -> WB, store -> FETCH.
REQ-009 WB: rf_we=1 for exactly one cycle, then -> FETCH. rf_we SHALL be 0 in every other state.
REQ-010 The PC SHALL update only on leaving EXECUTE (branch), MEM (store) or WB:
- JAL/JALR, or branch with branch_cond=1: next_pc = target_addr; JALR clears bit 0 first.
- otherwise: next_pc = pc+4, modulo 2^32 (32'hFFFF_FFFC -> 0).
REQ-011 target_addr is latched in EXECUTE for use in WB.
REQ-012 A taken target with bits[1:0] != 0 after masking SHALL go to HALT from EXECUTE with the PC unchanged; JAL/JALR SHALL NOT assert rf_we in that case.
REQ-013 instret SHALL increment by 1 on each PC update and wrap from 32'hFFFF_FFFF to 0.
REQ-014 HALT: absorbing state until reset. halted=1; all requests and rf_we are 0.
REQ-015 imem_ack outside FETCH and dmem_ack outside MEM SHALL be ignored.
REQ-016 Minimum latency per instruction, with ack on the first request cycle: ALU op 5 cycles, load 6, store 5, branch 4.

Reset
REQ-017 rst_n=0 SHALL immediately force state=FETCH, pc=RESET_PC, inst=0, instret=0, halted=0, imem_req=0, dmem_req=0, dmem_we=0, rf_we=0.
REQ-018 Assertion of rst_n mid-transaction SHALL drop any request combinationally-independent of clk; the first fetch SHALL be requested in the first cycle after rst_n is sampled high.

Verification
REQ-019 Reset, then ADDI (operation=32'h8000_0000) with imem_ack on the first request cycle -> rf_we pulses in cycle 5, pc=4, instret=1.
REQ-020 BEQ with branch_cond=1, target_addr=32'h100 -> no rf_we, pc=32'h100 after 4 cycles; same with branch_cond=0 -> pc=4.
REQ-021 LW with dmem_ack delayed 3 cycles -> dmem_req held 4 cycles, dmem_we=0, then one rf_we; SW -> dmem_we=1 and no rf_we.
REQ-022 operation=0, or operation=32'h0000_0003 -> HALT after DECODE, halted=1, pc unchanged, imem_req stays 0.
REQ-023 JAL with target_addr=32'h102 -> HALT, no rf_we; JALR with target 32'h201 -> pc=32'h200.
REQ-024 RESET_PC=32'hFFFF_FFFC with ADDI -> pc wraps to 0; rst_n pulsed low during MEM -> dmem_req drops at once and the fetch restarts at RESET_PC.

Source files
------------

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXECUTE/MEM/WB/HALT.
// Owns the PC, the latched instruction and the retired-instruction counter.
module multi_cycle_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  input  logic [31:0] operation,
  input  logic        branch_cond,
  input  logic [31:0] target_addr,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        rf_we,
  output logic [31:0] pc,
  output logic        halted,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_HALT
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] instret_q, instret_d;
  logic [31:0] target_q, target_d;
  logic        imem_req_q, imem_req_d;
  logic        mem_q, mem_d;
  logic        store_q, store_d;
  logic        branch_q, branch_d;
  logic        jal_q, jal_d;
  logic        jalr_q, jalr_d;

  logic        op_onehot;
  logic        taken;
  logic        pc_upd;
  logic [31:0] jump_tgt;
  logic [31:0] pc_plus4;
  logic [31:0] pc_new;

  assign op_onehot = (operation != 32'd0) && ((operation & (operation - 32'd1)) == 32'd0);
  assign jump_tgt  = jalr_q ? {target_addr[31:1], 1'b0} : target_addr;
  assign taken     = jal_q | jalr_q | (branch_q & branch_cond);
  assign pc_plus4  = pc_q + 32'd4;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    instret_d  = instret_q;
    target_d   = target_q;
    imem_req_d = 1'b0;
    mem_d      = mem_q;
    store_d    = store_q;
    branch_d   = branch_q;
    jal_d      = jal_q;
    jalr_d     = jalr_q;
    pc_upd     = 1'b0;
    pc_new     = pc_plus4;

    case (state_q)
      S_FETCH: begin
        // The request rises one cycle into FETCH; an ack is only honoured against it.
        if (imem_req_q && imem_ack) begin
          inst_d  = imem_rdata;
          state_d = S_DECODE;
        end else begin
          imem_req_d = 1'b1;
        end
      end
      S_DECODE: begin
        mem_d    = |operation[13:8];
        store_d  = |operation[10:8];
        branch_d = |operation[5:0];
        jal_d    = operation[7];
        jalr_d   = operation[6];
        state_d  = op_onehot ? S_EXECUTE : S_HALT;
      end
      S_EXECUTE: begin
        target_d = jump_tgt;
        if (taken && (jump_tgt[1:0] != 2'b00)) begin
          state_d = S_HALT;
        end else if (mem_q) begin
          state_d = S_MEM;
        end else if (branch_q) begin
          state_d = S_FETCH;
          pc_upd  = 1'b1;
          pc_new  = taken ? jump_tgt : pc_plus4;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (dmem_ack) begin
          if (store_q) begin
            state_d = S_FETCH;
            pc_upd  = 1'b1;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        state_d = S_FETCH;
        pc_upd  = 1'b1;
        pc_new  = (jal_q | jalr_q) ? target_q : pc_plus4;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_HALT;
      end
    endcase

    if (pc_upd) begin
      pc_d      = pc_new;
      instret_d = instret_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      inst_q     <= 32'd0;
      instret_q  <= 32'd0;
      target_q   <= 32'd0;
      imem_req_q <= 1'b0;
      mem_q      <= 1'b0;
      store_q    <= 1'b0;
      branch_q   <= 1'b0;
      jal_q      <= 1'b0;
      jalr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      instret_q  <= instret_d;
      target_q   <= target_d;
      imem_req_q <= imem_req_d;
      mem_q      <= mem_d;
      store_q    <= store_d;
      branch_q   <= branch_d;
      jal_q      <= jal_d;
      jalr_q     <= jalr_d;
    end
  end

  // State-decoded strobes fall with the asynchronous reset of state_q.
  assign imem_req  = imem_req_q;
  assign imem_addr = pc_q;
  assign inst      = inst_q;
  assign dmem_req  = (state_q == S_MEM);
  assign dmem_we   = (state_q == S_MEM) && store_q;
  assign rf_we     = (state_q == S_WB);
  assign pc        = pc_q;
  assign halted    = (state_q == S_HALT);
  assign instret   = instret_q;

endmodule
